mem_port_arbiter: RTL

- Shares one single-port, variable-latency unified memory between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Sits between the pipelined CPU core and the memory system.
- Sequences every memory transaction with a request/acknowledge handshake.
- Returns per-requester ready pulses and stall signals so the pipeline can freeze the waiting stage.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_arb_perf_cnt.sv | 38 +++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   - arbiter FSM state encoding
//   - default address / data / access-code widths
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: groups the core-side (IF and MEM stage) and memory-side
// handshake signals of the arbiter.
//   slave  : the arbiter's view (takes core requests and memory responses,
//            drives ready/stall/data back to the core and m_* to memory)
//   master : the environment's view (core pipeline plus memory system)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W,
    parameter int CTRL_W = mem_arb_pkg::CTRL_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [CTRL_W-1:0] d_ctrl;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              stall_if;
    logic              stall_mem;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [CTRL_W-1:0] m_ctrl;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_ctrl, m_ack, m_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
               m_req, m_we, m_addr, m_wdata, m_ctrl
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_ctrl, m_ack, m_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, stall_if, stall_mem,
               m_req, m_we, m_addr, m_wdata, m_ctrl
    );

endinterface

// File: rtl/mem_arb_perf_cnt.sv
// mem_arb_perf_cnt: saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear, wins over en
//   en       : count this cycle
//   cnt      : current count, sticks at all-ones
module mem_arb_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch stage and the load/store stage, one transaction at a time.
//   clk, rst     : clock, asynchronous active-low reset
//   bus (slave)  : if_* fetch port, d_* data port, stall_* to the pipeline,
//                  m_* request/acknowledge port to the memory
// Optional build macro MEM_ARB_PERF_CNT_EN adds:
//   perf_clr     : synchronous clear of both wait counters
//   perf_if_wait : cycles with stall_if = 1 (saturating)
//   perf_d_wait  : cycles with stall_mem = 1 (saturating)
//
// state     | meaning
// ARB_IDLE  | no transaction in flight, arbitrating every cycle
// ARB_IBUSY | fetch transaction outstanding, waiting for m_ack
// ARB_DBUSY | data transaction outstanding, waiting for m_ack
module mem_port_arbiter #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W,
    parameter int CTRL_W = mem_arb_pkg::CTRL_W
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
`ifdef MEM_ARB_PERF_CNT_EN
    input  logic                perf_clr,
    output logic [CNT_W-1:0]    perf_if_wait,
    output logic [CNT_W-1:0]    perf_d_wait,
`endif
    mem_port_arbiter_if.slave   bus
);
    import mem_arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;

    logic              elig_if;
    logic              elig_d;
    logic              grant_i;
    logic              grant_d;
    logic              ack;

    // A requester whose ready is pulsing still holds req for this cycle;
    // it must not be granted again before the core advances.
    assign elig_if = bus.if_req && !if_ready_q;
    assign elig_d  = bus.d_req  && !d_ready_q;

    // Data wins ties unless it won the previous grant.
    assign grant_d = elig_d  && (!elig_if || !last_d_q);
    assign grant_i = elig_if && (!elig_d  ||  last_d_q);

    assign ack = bus.m_ack && m_req_q;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_ctrl_d   = m_ctrl_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    state_d   = ARB_DBUSY;
                    last_d_d  = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_ctrl_d  = bus.d_ctrl;
                end else if (grant_i) begin
                    state_d   = ARB_IBUSY;
                    last_d_d  = 1'b0;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.if_addr;
                    m_wdata_d = '0;
                    m_ctrl_d  = '0;
                end
            end
            ARB_IBUSY: begin
                if (ack) begin
                    state_d = ARB_IDLE;
                    m_req_d = 1'b0;
                    // Fetch flushed while in flight: drop the result silently.
                    if (bus.if_req) begin
                        if_rdata_d = bus.m_rdata;
                        if_ready_d = 1'b1;
                    end
                end
            end
            ARB_DBUSY: begin
                if (ack) begin
                    state_d = ARB_IDLE;
                    m_req_d = 1'b0;
                    if (bus.d_req) begin
                        d_rdata_d = bus.m_rdata;
                        d_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            last_d_q   <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_ctrl_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_ctrl_q   <= m_ctrl_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
        end
    end

    assign bus.m_req     = m_req_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.m_ctrl    = m_ctrl_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.stall_if  = bus.if_req && !if_ready_q;
    assign bus.stall_mem = bus.d_req  && !d_ready_q;

`ifdef MEM_ARB_PERF_CNT_EN
    mem_arb_perf_cnt #(.CNT_W(CNT_W)) u_perf_if (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .en  (bus.stall_if),
        .cnt (perf_if_wait)
    );

    mem_arb_perf_cnt #(.CNT_W(CNT_W)) u_perf_d (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .en  (bus.stall_mem),
        .cnt (perf_d_wait)
    );
`endif

endmodule
